// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter FSM states.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; head word is visible whenever valid_o is high.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (count != '0);
  assign full_o  = (count == FULL_CNT);
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  // A pop on a full FIFO frees the slot in the same cycle, so the push may proceed.
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a small receive FIFO, with sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  input  logic       err_clr_i,
  output logic       busy_o
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_e          state;
  logic [15:0]          cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 busy_q;
  logic                 stop_tick;
  logic                 push_req;
  logic                 frame_set;
  logic                 overflow_set;
  logic                 fifo_full;
  logic                 pop;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt    <= HALF_LOAD;
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= FULL_LOAD;
            if (bit_idx == LAST_IDX) state <= STOP;
            else bit_idx <= bit_idx + IDX_W'(1);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          // Re-arm at the stop-bit centre so a following start edge is not missed.
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign stop_tick    = (state == STOP) && (cnt == '0);
  assign push_req     = stop_tick && rx_s;
  assign frame_set    = stop_tick && !rx_s;
  assign pop          = rx_valid_o && rx_ready_i;
  assign overflow_set = push_req && fifo_full && !pop;
  assign busy_o       = busy_q;

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_req),
    .data_i (shreg),
    .pop_i  (rx_ready_i),
    .data_o (rx_data_o),
    .valid_o(rx_valid_o),
    .full_o (fifo_full)
  );

  // A set event in the same cycle as err_clr_i takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (frame_set)      frame_err_o <= 1'b1;
      else if (err_clr_i) frame_err_o <= 1'b0;
      if (overflow_set)   overflow_o  <= 1'b1;
      else if (err_clr_i) overflow_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected bytes, a monitor pops and compares.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       frame_err_o;
  logic       overflow_o;
  logic       err_clr_i = 1'b0;
  logic       busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .err_clr_i  (err_clr_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Tasks below are entered and left on a falling clock edge.
  task automatic idle(input int cycles);
    rx_i = 1'b1;
    repeat (cycles) @(negedge clk_i);
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk_i);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head word must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i && rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got 0x%0h expected no data", rx_data_o);
        end else begin
          check("pop_data", rx_data_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 0);
    check("rst_frame", frame_err_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    idle(5);

    // Back-to-back frames with consumer ready
    rx_ready_i = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    wait_drain("drain_b2b", 20);
    check("b2b_frame", frame_err_o, 0);
    check("b2b_ovf", overflow_o, 0);
    idle(10);

    // Short low glitch on an idle line
    rx_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("glitch_busy_hi", busy_o, 1);
    @(negedge clk_i);
    idle(20);
    check("glitch_busy_lo", busy_o, 0);
    check("glitch_valid", rx_valid_o, 0);
    check("glitch_frame", frame_err_o, 0);
    check("glitch_ovf", overflow_o, 0);

    // Stop bit sampled low
    send_byte(8'h3C, 1'b0);
    idle(40);
    check("ferr_set", frame_err_o, 1);
    check("ferr_valid", rx_valid_o, 0);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    @(negedge clk_i);
    check("ferr_clr", frame_err_o, 0);

    // Overflow: five bytes into a four-entry FIFO with no consumer
    rx_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    idle(4);
    check("ovf_set", overflow_o, 1);
    check("ovf_valid", rx_valid_o, 1);
    check("ovf_head", rx_data_o, 8'h01);
    rx_ready_i = 1'b1;
    wait_drain("drain_ovf", 20);
    idle(2);
    check("ovf_empty", rx_valid_o, 0);
    rx_ready_i = 1'b0;
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    @(negedge clk_i);
    check("ovf_clr", overflow_o, 0);

    // Full FIFO: the 5th stop sample coincides with a single pop
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
    idle(10);
    check("full_ovf_pre", overflow_o, 0);
    fork
      send_byte(8'h15, 1'b1);
      begin
        // Stop sample lands on the 155th rising edge after the start bit is driven.
        repeat (154) @(negedge clk_i);
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
      end
    join
    idle(4);
    check("full_pop_ovf", overflow_o, 0);
    check("full_pop_cnt", exp_q.size(), 4);
    rx_ready_i = 1'b1;
    wait_drain("drain_full", 20);

    // Reset during data bit 4 of 0xFF, with a frame error pending
    send_byte(8'h3C, 1'b0);
    idle(40);
    check("pre_rst_ferr", frame_err_o, 1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (CPB * 4 + 8) @(negedge clk_i);
    check("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_valid", rx_valid_o, 0);
    check("mid_rst_data", rx_data_o, 0);
    check("mid_rst_frame", frame_err_o, 0);
    check("mid_rst_ovf", overflow_o, 0);
    rst_i = 1'b0;
    idle(200);
    check("post_rst_busy", busy_o, 0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(5);
    wait_drain("drain_rst", 20);
    check("post_rst_frame", frame_err_o, 0);
    check("post_rst_ovf", overflow_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
